// File: rtl/mem_reg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_reg_sequencer_pkg
//  Description : Shared types for the SRAM <-> register-file transfer
//                sequencer: operation mode encodings, FSM state encoding and
//                a small helper that classifies read-back modes.
//  Contents    : mode_e      - 2-bit operation code as seen on the mode port
//                state_e     - sequencer FSM states
//                is_read_mode- true for modes that read the SRAM
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_reg_sequencer_pkg;

   typedef enum logic [1:0] {
      MODE_FILL   = 2'd0,
      MODE_LOAD   = 2'd1,
      MODE_STORE  = 2'd2,
      MODE_VERIFY = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Modes whose data comes back through the SRAM read pipe.
   function automatic logic is_read_mode(input mode_e m);
      return (m == MODE_LOAD) || (m == MODE_VERIFY);
   endfunction

endpackage : mem_reg_sequencer_pkg
`default_nettype wire

// File: rtl/mem_reg_sequencer_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_lat_pipe
//  Description : LAT-stage shift register carrying a valid bit and a register
//                index alongside an SRAM read, so the returning data can be
//                matched to its destination register. Synchronous flush on rst.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                valid_i/idx_i - read issued this cycle and its register index
//                valid_o/idx_o - delayed LAT cycles, aligned with SRAM rdata
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_lat_pipe #(
   parameter int LAT   = 1,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [LAT-1:0]   valid_q;
   logic [IDX_W-1:0] idx_q [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < LAT; k++) begin
            idx_q[k] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         idx_q[0]   <= idx_i;
         for (int k = 1; k < LAT; k++) begin
            valid_q[k] <= valid_q[k-1];
            idx_q[k]   <= idx_q[k-1];
         end
      end
   end

   assign valid_o = valid_q[LAT-1];
   assign idx_o   = idx_q[LAT-1];

endmodule : rd_lat_pipe
`default_nettype wire

// File: rtl/mem_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_reg_sequencer
//  Description : start/busy/done sequencer moving words between a single-port
//                synchronous SRAM and a 2R/1W register file. Modes: pattern
//                FILL, LOAD (mem->reg), STORE (reg->mem), VERIFY (compare).
//  Ports       : start_i/mode_i/mem_base_i/reg_base_i/count_i/fill_seed_i
//                              - request, latched in IDLE
//                busy_o/done_o/err_o/mismatch_cnt_o - status
//                mem_*         - SRAM address/write/read
//                reg_*         - register-file read port and write port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_reg_sequencer #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 11,
   parameter int REG_AW     = 5,
   parameter int MEM_RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [1:0]          mode_i,
   input  logic [ADDR_W-1:0]   mem_base_i,
   input  logic [REG_AW-1:0]   reg_base_i,
   input  logic [REG_AW:0]     count_i,
   input  logic [DATA_W-1:0]   fill_seed_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [REG_AW:0]     mismatch_cnt_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic [REG_AW-1:0]   reg_rd_addr_o,
   input  logic [31:0]         reg_rd_data_i,
   output logic                reg_wr_en_o,
   output logic [REG_AW-1:0]   reg_wr_addr_o,
   output logic [31:0]         reg_wr_data_o
);

   import mem_reg_sequencer_pkg::*;

   localparam int REG_DEPTH = 2 ** REG_AW;
   localparam int CNT_W     = REG_AW + 1;
   localparam int SUM_W     = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;
   localparam int DR_W      = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

   state_e             state_q;
   mode_e              mode_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   idx_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [REG_AW-1:0]  reg_idx_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               we_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic [CNT_W-1:0]   mismatch_q;
   logic [DR_W-1:0]    drain_q;

   logic [SUM_W-1:0]   end_d;
   logic               reject_d;
   logic               last_d;
   logic               rd_issue_d;
   logic               mis_hit_d;
   logic               pipe_vld;
   logic [REG_AW-1:0]  pipe_idx;

   // addr_q still holds mem_base during CHECK; the end address must not pass
   // the top of the SRAM, so the sum is formed one bit wider than either term.
   assign end_d    = SUM_W'(addr_q) + SUM_W'(count_q);
   assign reject_d = (count_q == '0)
                  || (count_q > CNT_W'(REG_DEPTH))
                  || (end_d > (SUM_W'(1) << ADDR_W));

   assign last_d     = (idx_q == (count_q - CNT_W'(1)));
   assign rd_issue_d = (state_q == ST_RUN) && is_read_mode(mode_q);

   rd_lat_pipe #(
      .LAT   (MEM_RD_LAT),
      .IDX_W (REG_AW)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .valid_i (rd_issue_d),
      .idx_i   (reg_idx_q),
      .valid_o (pipe_vld),
      .idx_o   (pipe_idx)
   );

   assign mis_hit_d = pipe_vld && (mode_q == MODE_VERIFY)
                   && (mem_rdata_i != reg_rd_data_i[DATA_W-1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_FILL;
         count_q    <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         reg_idx_q  <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         mismatch_q <= '0;
         drain_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  mode_q     <= mode_e'(mode_i);
                  count_q    <= count_i;
                  addr_q     <= mem_base_i;
                  reg_idx_q  <= reg_base_i;
                  wdata_q    <= fill_seed_i;
                  idx_q      <= '0;
                  err_q      <= 1'b0;
                  mismatch_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (reject_d) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  we_q    <= !is_read_mode(mode_q);
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (last_d) begin
                  we_q <= 1'b0;
                  if (is_read_mode(mode_q)) begin
                     drain_q <= DR_W'(MEM_RD_LAT - 1);
                     state_q <= ST_DRAIN;
                  end else begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_DONE;
                  end
               end else begin
                  idx_q     <= idx_q + CNT_W'(1);
                  addr_q    <= addr_q + ADDR_W'(1);
                  reg_idx_q <= reg_idx_q + REG_AW'(1);   // wraps mod REG_DEPTH
                  wdata_q   <= wdata_q - DATA_W'(1);
               end
            end
            ST_DRAIN: begin
               // The final read returns during the last DRAIN cycle.
               if (drain_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  drain_q <= drain_q - DR_W'(1);
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase

         // The pipe is empty in IDLE, so this never collides with the clear.
         if (mis_hit_d) begin
            mismatch_q <= mismatch_q + CNT_W'(1);
         end
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign mismatch_cnt_o = mismatch_q;
   assign mem_addr_o     = addr_q;
   assign mem_we_o       = we_q;

   // STORE forwards the combinational register-file read straight to the SRAM.
   assign mem_wdata_o   = (we_q && (mode_q == MODE_STORE)) ? reg_rd_data_i[DATA_W-1:0]
                                                           : wdata_q;
   // VERIFY reads the register that matches the returning SRAM word.
   assign reg_rd_addr_o = (mode_q == MODE_VERIFY) ? pipe_idx : reg_idx_q;

   assign reg_wr_en_o   = pipe_vld && (mode_q == MODE_LOAD);
   assign reg_wr_addr_o = pipe_idx;
   assign reg_wr_data_o = reg_wr_en_o ? 32'(mem_rdata_i) : 32'd0;

   if (DATA_W < 32) begin : g_rd_hi
      logic unused_rd_hi;
      assign unused_rd_hi = ^reg_rd_data_i[31:DATA_W];
   end

endmodule : mem_reg_sequencer
`default_nettype wire

// File: tb/tb_mem_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_reg_sequencer
//  Description : Directed, table-driven bench for mem_reg_sequencer with
//                behavioural SRAM (1-cycle read) and register-file models and
//                bench-side shadow images of both memories.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_reg_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [10:0] mem_base = '0;
   logic [4:0]  reg_base = '0;
   logic [5:0]  count = '0;
   logic [15:0] fill_seed = '0;
   logic        busy, done, err;
   logic [5:0]  mismatch_cnt;
   logic [10:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata, mem_rdata;
   logic [4:0]  reg_rd_addr, reg_wr_addr;
   logic [31:0] reg_rd_data, reg_wr_data;
   logic        reg_wr_en;

   logic        poke_en = 1'b0;
   logic [10:0] poke_addr = '0;
   logic [15:0] poke_data = '0;

   always #5 clk = ~clk;

   mem_reg_sequencer dut (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
      .mem_base_i(mem_base), .reg_base_i(reg_base), .count_i(count),
      .fill_seed_i(fill_seed), .busy_o(busy), .done_o(done), .err_o(err),
      .mismatch_cnt_o(mismatch_cnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .reg_rd_addr_o(reg_rd_addr), .reg_rd_data_i(reg_rd_data),
      .reg_wr_en_o(reg_wr_en), .reg_wr_addr_o(reg_wr_addr),
      .reg_wr_data_o(reg_wr_data)
   );

   // SRAM and register-file models
   logic [15:0] sram [2048] = '{default: 16'h0};
   logic [15:0] rd_q = '0;
   logic [31:0] rf [32] = '{default: 32'h0};

   always @(posedge clk) begin
      if (poke_en) sram[poke_addr] <= poke_data;
      else if (mem_we) sram[mem_addr] <= mem_wdata;
      rd_q <= sram[mem_addr];
   end
   assign mem_rdata = rd_q;

   always @(posedge clk) if (reg_wr_en) rf[reg_wr_addr] <= reg_wr_data;
   assign reg_rd_data = rf[reg_rd_addr];

   // Shadow images the bench expects the memories to hold
   logic [15:0] exp_mem [2048] = '{default: 16'h0};
   logic [31:0] exp_rf  [32]   = '{default: 32'h0};

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [10:0] mb;
      logic [4:0]  rb;
      logic [5:0]  cnt;
      logic [15:0] seed;
      logic        poke;
      logic [10:0] paddr;
      logic [15:0] pdata;
      logic        mid;    // pulse a stray start during RUN
      logic        dns;    // pulse start in the DONE cycle
      logic        eerr;
      int          elat;   // cycle of done, start cycle = 0
      logic [5:0]  emis;
   } vec_t;

   task automatic update_shadow(input vec_t v);
      for (int i = 0; i < int'(v.cnt); i++) begin
         int ma;
         int ri;
         ma = int'(v.mb) + i;
         ri = (int'(v.rb) + i) % 32;
         case (v.mode)
            2'd0: exp_mem[ma] = v.seed - 16'(i);
            2'd1: exp_rf[ri]  = {16'h0, exp_mem[ma]};
            2'd2: exp_mem[ma] = exp_rf[ri][15:0];
            default: ;
         endcase
      end
   endtask

   task automatic cmp_images(input string tag);
      int dm;
      int dr;
      dm = 0;
      dr = 0;
      for (int a = 0; a < 2048; a++) if (sram[a] !== exp_mem[a]) dm++;
      for (int r = 0; r < 32; r++)   if (rf[r] !== exp_rf[r]) dr++;
      chk({tag, " mem_image_diffs"}, 64'(dm), 64'd0);
      chk({tag, " reg_image_diffs"}, 64'(dr), 64'd0);
   endtask

   task automatic run_op(input vec_t v, input int id);
      int   cyc;
      int   we_n;
      int   wr_n;
      logic seen;
      string tag;
      tag = $sformatf("v%0d", id);
      if (v.poke) begin
         poke_en = 1'b1; poke_addr = v.paddr; poke_data = v.pdata;
         @(posedge clk); #1;
         poke_en = 1'b0;
         exp_mem[v.paddr] = v.pdata;
      end
      start = 1'b1; mode = v.mode; mem_base = v.mb; reg_base = v.rb;
      count = v.cnt; fill_seed = v.seed;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; we_n = 0; wr_n = 0; seen = 1'b0;
      chk({tag, " busy_cycle1"}, 64'(busy), 64'd1);
      while (cyc < 200) begin
         if (mem_we) we_n++;
         if (reg_wr_en) wr_n++;
         if (v.mid && cyc == 5) begin
            start = 1'b1; mode = 2'd2; mem_base = 11'h100; reg_base = 5'd3;
            count = 6'd7; fill_seed = 16'h5555;
         end else if (v.mid && cyc == 6) begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, " done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({tag, " done_latency"}, 64'(cyc), 64'(v.elat));
         chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
         chk({tag, " err"}, 64'(err), 64'(v.eerr));
         chk({tag, " mismatch_cnt"}, 64'(mismatch_cnt), 64'(v.emis));
      end
      if (v.dns) begin
         start = 1'b1; mode = 2'd0; mem_base = 11'h7FF; count = 6'd1;
         fill_seed = 16'hDEAD;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " busy_after_done"}, 64'(busy), 64'd0);
      chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
      chk({tag, " err_held"}, 64'(err), 64'(v.eerr));
      chk({tag, " mismatch_held"}, 64'(mismatch_cnt), 64'(v.emis));
      chk({tag, " mem_we_pulses"}, 64'(we_n),
          64'((!v.eerr && (v.mode == 2'd0 || v.mode == 2'd2)) ? int'(v.cnt) : 0));
      chk({tag, " reg_wr_pulses"}, 64'(wr_n),
          64'((!v.eerr && v.mode == 2'd1) ? int'(v.cnt) : 0));
      if (!v.eerr) update_shadow(v);
      cmp_images(tag);
   endtask

   localparam int NV = 14;
   vec_t vt [NV];

   initial begin
      int cyc;
      int stray;
      vec_t vr;

      //            mode   mb       rb     cnt    seed      pk  paddr   pdata     mid  dns  eerr lat mis
      vt[0]  = '{2'd0, 11'd0,    5'd0,  6'd32, 16'd127, 0, 11'd0,  16'h0,    1, 0, 0, 34, 6'd0};
      vt[1]  = '{2'd0, 11'd64,   5'd0,  6'd32, 16'd127, 0, 11'd0,  16'h0,    0, 1, 0, 34, 6'd0};
      vt[2]  = '{2'd1, 11'd0,    5'd30, 6'd4,  16'd0,   0, 11'd0,  16'h0,    0, 0, 0,  7, 6'd0};
      vt[3]  = '{2'd1, 11'd64,   5'd0,  6'd32, 16'd0,   0, 11'd0,  16'h0,    0, 0, 0, 35, 6'd0};
      vt[4]  = '{2'd2, 11'd145,  5'd16, 6'd16, 16'd0,   0, 11'd0,  16'h0,    0, 0, 0, 18, 6'd0};
      vt[5]  = '{2'd0, 11'd2032, 5'd0,  6'd16, 16'd5,   0, 11'd0,  16'h0,    0, 0, 0, 18, 6'd0};
      vt[6]  = '{2'd3, 11'd64,   5'd0,  6'd32, 16'd0,   1, 11'd70, 16'hBEEF, 0, 0, 0, 35, 6'd1};
      vt[7]  = '{2'd3, 11'd64,   5'd0,  6'd32, 16'd0,   1, 11'd70, 16'h0079, 0, 0, 0, 35, 6'd0};
      vt[8]  = '{2'd3, 11'd2032, 5'd0,  6'd16, 16'd0,   0, 11'd0,  16'h0,    0, 0, 0, 19, 6'd16};
      vt[9]  = '{2'd3, 11'd145,  5'd16, 6'd16, 16'd0,   0, 11'd0,  16'h0,    0, 0, 0, 19, 6'd0};
      vt[10] = '{2'd0, 11'd0,    5'd0,  6'd0,  16'd9,   0, 11'd0,  16'h0,    0, 0, 1,  2, 6'd0};
      vt[11] = '{2'd1, 11'd0,    5'd0,  6'd33, 16'd0,   0, 11'd0,  16'h0,    0, 0, 1,  2, 6'd0};
      vt[12] = '{2'd2, 11'd2040, 5'd0,  6'd16, 16'd0,   0, 11'd0,  16'h0,    0, 0, 1,  2, 6'd0};
      vt[13] = '{2'd3, 11'd0,    5'd0,  6'd1,  16'd0,   0, 11'd0,  16'h0,    0, 0, 0,  4, 6'd0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst err", 64'(err), 64'd0);
      chk("rst mem_we", 64'(mem_we), 64'd0);
      chk("rst reg_wr_en", 64'(reg_wr_en), 64'd0);
      chk("rst mismatch_cnt", 64'(mismatch_cnt), 64'd0);
      chk("rst mem_addr", 64'(mem_addr), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int n = 0; n < NV; n++) run_op(vt[n], n);

      // Reset in the middle of a 32-word LOAD (reloads identical data so the
      // shadow images stay valid whatever was written before the reset).
      start = 1'b1; mode = 2'd1; mem_base = 11'd64; reg_base = 5'd0;
      count = 6'd32;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("midrst busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst reg_wr_en", 64'(reg_wr_en), 64'd0);
      chk("midrst mem_addr", 64'(mem_addr), 64'd0);
      stray = 0;
      for (int k = 0; k < 40; k++) begin
         if (reg_wr_en || mem_we || done || busy) stray++;
         @(posedge clk); #1;
      end
      chk("midrst stray_activity", 64'(stray), 64'd0);
      cmp_images("midrst");

      // The sequencer must work normally after the abort.
      vr = '{2'd3, 11'd64, 5'd0, 6'd32, 16'd0, 0, 11'd0, 16'h0, 0, 0, 0, 35, 6'd0};
      run_op(vr, 99);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_mem_reg_sequencer
`default_nettype wire
